// File: rtl/ps2_rx_frontend.sv
// PS/2 device-to-host receiver: pin synchronization, clock deglitch, 11-bit frame
// deserialization and a one-entry valid/ready holding register.
// Optional build macro: PS2_PARITY_CHECK_EN enables rejection of frames with bad parity.
module ps2_rx_frontend #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [1:0] state_dbg
);

  // Handshake: a byte moves to the consumer on every rising clk edge where
  // key_valid & key_ready; key_data holds steady while key_valid is high.

  localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic [FW-1:0]          flt_cnt;
  logic                   clk_f, clk_f_q;
  logic                   fe, data_bit;
  logic [TW-1:0]          to_cnt;
  logic                   timeout_hit;
  logic [3:0]             bit_cnt, bit_cnt_n;
  logic [7:0]             sh, sh_n;
  logic                   parity_ok;
  logic                   frame_good, frame_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      flt_cnt   <= '0;
      clk_f     <= 1'b1;
      clk_f_q   <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_f_q   <= clk_f;
      // clk_f follows the synchronized pin only after FILTER_LEN agreeing samples
      if (clk_sync[SYNC_STAGES-1] != clk_f) begin
        if (flt_cnt == FW'(FILTER_LEN - 1)) begin
          clk_f   <= clk_sync[SYNC_STAGES-1];
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign fe          = clk_f_q & ~clk_f;
  assign data_bit    = data_sync[SYNC_STAGES-1];
  assign timeout_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state == IDLE || fe) begin
      to_cnt <= '0;
    end else if (!timeout_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par, par_n;

  always_ff @(posedge clk) begin
    if (rst) par <= 1'b0;
    else     par <= par_n;
  end

  assign parity_ok = ^{sh, par};
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    sh_n       = sh;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_n      = par;
`endif
    case (state)
      IDLE: begin
        if (fe && !data_bit) begin
          state_n   = RECV;
          bit_cnt_n = 4'd0;
        end
      end
      RECV: begin
        if (fe) begin
          if (bit_cnt == 4'd8) begin
            state_n = STOP;
`ifdef PS2_PARITY_CHECK_EN
            par_n   = data_bit;
`endif
          end else begin
            sh_n      = {data_bit, sh[7:1]};
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end else if (timeout_hit) begin
          state_n   = IDLE;
          frame_bad = 1'b1;
        end
      end
      STOP: begin
        if (fe) begin
          state_n = IDLE;
          if (data_bit && parity_ok) frame_good = 1'b1;
          else                       frame_bad  = 1'b1;
        end else if (timeout_hit) begin
          state_n   = IDLE;
          frame_bad = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      sh        <= 8'h00;
      key_data  <= 8'h00;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      sh        <= sh_n;
      frame_err <= frame_bad;
      overrun   <= 1'b0;
      // A consumer accepting in the same cycle frees the slot for the new byte
      if (frame_good) begin
        if (!key_valid || key_ready) begin
          key_data  <= sh;
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
